// File: rtl/ex_mul_unit_pkg.sv
// Shared constants and operand helpers for the EX-stage multiplier.
// The command and status encodings mirror the core-wide definitions.
package ex_mul_unit_pkg;

  localparam logic [5:0]  JX2_UCMD_MUL3  = 6'h0B;
  localparam logic [5:0]  JX2_UCMD_MULW3 = 6'h0C;

  localparam logic [1:0]  UMEM_OK_READY  = 2'h0;
  localparam logic [1:0]  UMEM_OK_OK     = 2'h1;
  localparam logic [1:0]  UMEM_OK_HOLD   = 2'h2;

  localparam logic [31:0] UV32_00        = 32'h0000_0000;
  localparam logic [31:0] UV32_FF        = 32'hFFFF_FFFF;

  // Edges from operand capture to a valid MUL3 result; EX2 waits exactly this long.
  localparam int          MUL_LAT        = 3;

  function automatic logic [32:0] extOp33(input logic [31:0] v, input logic isUns);
    return {(isUns ? 1'b0 : v[31]), v};
  endfunction

  function automatic logic [16:0] extOp17(input logic [15:0] v, input logic isUns);
    return {(isUns ? 1'b0 : v[15]), v};
  endfunction

  function automatic logic [63:0] sext34(input logic [33:0] p);
    return {{30{p[33]}}, p};
  endfunction

endpackage

// File: rtl/ex_mul_pp17.sv
// One registered 17x17 signed multiplier; the product updates only when enabled.
module ex_mul_pp17 (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic [16:0] valA,
  input  logic [16:0] valB,
  output logic [33:0] valP
);

  always_ff @(posedge clock) begin
    if (reset)
      valP <= '0;
    else if (enable)
      valP <= $signed(valA) * $signed(valB);
  end

endmodule

// File: rtl/ex_mul_unit.sv
// Multi-cycle EX multiplier: 32x32->64 MUL3 through registered 16-bit partial
// products, plus a single-cycle 16x16->32 MULW3 path that runs independently.
module ex_mul_unit
  import ex_mul_unit_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  opUCmd,
  input  logic [7:0]  opUIxt,
  input  logic        opBraFlush,
  input  logic        exHold,
  input  logic [63:0] regValRs,
  input  logic [63:0] regValRt,
  output logic [63:0] regValMulRes,
  output logic [63:0] regValMulwRes,
  output logic [1:0]  mulOK
);

  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_PP   = 2'd1,
    MUL_SUM  = 2'd2,
    MUL_DONE = 2'd3
  } mulState_t;

  mulState_t   stateReg, stateNext;

  logic        capOk, mul3Cap, mulwCap, isUns;
  logic [32:0] opAReg, opBReg;
  logic        ppEn;
  logic [16:0] ppA [4];
  logic [16:0] ppB [4];
  logic [33:0] ppP [4];
  logic [63:0] sumNext;
  logic [33:0] mulwP;
  logic        mulwSignedReg;
  logic        unusedOk;

  assign isUns   = opUIxt[0];
  assign capOk   = !exHold && !opBraFlush;
  assign mul3Cap = capOk && (opUCmd[5:0] == JX2_UCMD_MUL3);
  assign mulwCap = capOk && (opUCmd[5:0] == JX2_UCMD_MULW3);

  // Predicate bits, spare extension bits and upper register halves carry no meaning here.
  assign unusedOk = ^{opUCmd[7:6], opUIxt[7:1], regValRs[63:32], regValRt[63:32],
                      regValRs[31:16] & regValRt[31:16], mulwP[33:32]};

  // Operands are widened to 33 bits so one signed datapath covers both signednesses.
  always_ff @(posedge clock) begin
    if (reset) begin
      opAReg <= '0;
      opBReg <= '0;
    end else if (mul3Cap) begin
      opAReg <= extOp33(regValRs[31:0], isUns);
      opBReg <= extOp33(regValRt[31:0], isUns);
    end
  end

  always_ff @(posedge clock) begin
    if (reset)
      stateReg <= MUL_IDLE;
    else
      stateReg <= stateNext;
  end

  always_comb begin
    stateNext = stateReg;
    mulOK     = UMEM_OK_READY;
    case (stateReg)
      MUL_IDLE: begin
        stateNext = MUL_IDLE;
        mulOK     = UMEM_OK_READY;
      end
      MUL_PP: begin
        stateNext = MUL_SUM;
        mulOK     = UMEM_OK_HOLD;
      end
      MUL_SUM: begin
        stateNext = MUL_DONE;
        mulOK     = UMEM_OK_HOLD;
      end
      MUL_DONE: begin
        stateNext = exHold ? MUL_DONE : MUL_IDLE;
        mulOK     = UMEM_OK_OK;
      end
      default: begin
        stateNext = MUL_IDLE;
        mulOK     = UMEM_OK_READY;
      end
    endcase
    if (mul3Cap)
      stateNext = MUL_PP;
  end

  assign ppEn = (stateReg == MUL_PP);

  // Index bit 1 selects the A half, bit 0 the B half: 0=ll, 1=lh, 2=hl, 3=hh.
  // Low halves get a zero top bit; high halves keep the 33-bit sign.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_pp
      localparam int A_HI = gi / 2;
      localparam int B_HI = gi % 2;

      assign ppA[gi] = (A_HI == 1) ? opAReg[32:16] : {1'b0, opAReg[15:0]};
      assign ppB[gi] = (B_HI == 1) ? opBReg[32:16] : {1'b0, opBReg[15:0]};

      ex_mul_pp17 u_pp (
        .clock  (clock),
        .reset  (reset),
        .enable (ppEn),
        .valA   (ppA[gi]),
        .valB   (ppB[gi]),
        .valP   (ppP[gi])
      );
    end
  endgenerate

  assign sumNext = sext34(ppP[0])
                 + ((sext34(ppP[1]) + sext34(ppP[2])) << 16)
                 + (sext34(ppP[3]) << 32);

  // Result only moves on the SUM edge, so EX2 sees a frozen value through DONE.
  always_ff @(posedge clock) begin
    if (reset)
      regValMulRes <= '0;
    else if (stateReg == MUL_SUM)
      regValMulRes <= sumNext;
  end

  ex_mul_pp17 u_mulw (
    .clock  (clock),
    .reset  (reset),
    .enable (mulwCap),
    .valA   (extOp17(regValRs[15:0], isUns)),
    .valB   (extOp17(regValRt[15:0], isUns)),
    .valP   (mulwP)
  );

  always_ff @(posedge clock) begin
    if (reset)
      mulwSignedReg <= 1'b0;
    else if (mulwCap)
      mulwSignedReg <= !isUns;
  end

  assign regValMulwRes = {(mulwSignedReg && mulwP[31]) ? UV32_FF : UV32_00, mulwP[31:0]};

endmodule

// File: tb/tb_ex_mul_unit.sv
// Scoreboard bench for ex_mul_unit: stimulus queues expected products, a
// negedge monitor pops and compares when the unit presents a result.
module tb_ex_mul_unit;
  import ex_mul_unit_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  opUCmd = 8'h00;
  logic [7:0]  opUIxt = 8'h00;
  logic        opBraFlush = 1'b0;
  logic        exHold = 1'b0;
  logic [63:0] regValRs = '0;
  logic [63:0] regValRt = '0;
  logic [63:0] regValMulRes;
  logic [63:0] regValMulwRes;
  logic [1:0]  mulOK;

  typedef struct {
    logic [63:0] val;
    int          capCyc;
  } exp_t;

  exp_t mulQ[$];
  exp_t mulwQ[$];
  int   vecs = 0;
  int   errs = 0;
  int   cyc = 0;
  logic [1:0] prevOk = UMEM_OK_READY;

  ex_mul_unit dut (
    .clock         (clock),
    .reset         (reset),
    .opUCmd        (opUCmd),
    .opUIxt        (opUIxt),
    .opBraFlush    (opBraFlush),
    .exHold        (exHold),
    .regValRs      (regValRs),
    .regValRt      (regValRt),
    .regValMulRes  (regValMulRes),
    .regValMulwRes (regValMulwRes),
    .mulOK         (mulOK)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc = cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: got still running, expected finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  // Drives one uop for a single capture edge, then returns to a NOP.
  task automatic issue(input logic [5:0] cmd, input logic isUns, input logic [63:0] a,
                       input logic [63:0] b, input logic flush, input logic hold,
                       input logic [63:0] expVal, input logic doExp);
    exp_t e;
    opUCmd     = {2'b10, cmd};
    opUIxt     = {7'h55, isUns};
    regValRs   = a;
    regValRt   = b;
    opBraFlush = flush;
    exHold     = hold;
    e.val      = expVal;
    e.capCyc   = cyc + 1;
    if (doExp) begin
      if (cmd == JX2_UCMD_MUL3) mulQ.push_back(e);
      else mulwQ.push_back(e);
    end
    @(posedge clock);
    #1;
    opUCmd     = 8'h00;
    opUIxt     = 8'h00;
    opBraFlush = 1'b0;
    exHold     = 1'b0;
    regValRs   = 64'h0123_4567_89AB_CDEF;
    regValRt   = 64'hFEDC_BA98_7654_3210;
  endtask

  // Returns on the negedge where mulOK matches; a timeout is a failed comparison.
  task automatic waitFor(input logic [1:0] tgt, input int maxc, input string name);
    for (int i = 0; i < maxc; i++) begin
      @(negedge clock);
      if (mulOK == tgt) return;
    end
    check(name, 64'(mulOK), 64'(tgt));
  endtask

  always @(negedge clock) begin
    if (mulOK == UMEM_OK_OK && prevOk != UMEM_OK_OK) begin
      if (mulQ.size() == 0) begin
        check("mul3_unexpected_done", 64'(mulOK), 64'(UMEM_OK_READY));
      end else begin
        exp_t e;
        e = mulQ.pop_front();
        check("mul3_result", regValMulRes, e.val);
        check("mul3_latency", 64'(cyc - e.capCyc + 1), 64'(MUL_LAT));
      end
    end
    prevOk = mulOK;
    if (mulwQ.size() > 0 && mulwQ[0].capCyc <= cyc) begin
      exp_t w;
      w = mulwQ.pop_front();
      check("mulw_result", regValMulwRes, w.val);
    end
  end

  initial begin
    reset = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("reset_mulOK", 64'(mulOK), 64'(UMEM_OK_READY));
    check("reset_mulRes", regValMulRes, 64'h0);
    check("reset_mulwRes", regValMulwRes, 64'h0);
    reset = 1'b0;
    @(posedge clock);
    #1;

    issue(JX2_UCMD_MUL3, 1'b1, 64'hDEADBEEF_FFFFFFFF, 64'h00000002, 0, 0, 64'h00000001_FFFFFFFE, 1);
    waitFor(UMEM_OK_OK, 5, "m1_done");
    waitFor(UMEM_OK_READY, 3, "m1_idle");

    issue(JX2_UCMD_MUL3, 1'b0, 64'h00000000_FFFFFFFF, 64'h12345678_00000002, 0, 0, 64'hFFFFFFFF_FFFFFFFE, 1);
    waitFor(UMEM_OK_OK, 5, "m2_done");
    waitFor(UMEM_OK_READY, 3, "m2_idle");

    issue(JX2_UCMD_MUL3, 1'b0, 64'h80000000, 64'h80000000, 0, 0, 64'h40000000_00000000, 1);
    waitFor(UMEM_OK_OK, 5, "m3_done");
    waitFor(UMEM_OK_READY, 3, "m3_idle");

    issue(JX2_UCMD_MUL3, 1'b1, 64'hFFFFFFFF, 64'hFFFFFFFF, 0, 0, 64'hFFFFFFFE_00000001, 1);
    exHold = 1'b1;
    waitFor(UMEM_OK_OK, 5, "m4_done");
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      check("hold_mulOK", 64'(mulOK), 64'(UMEM_OK_OK));
      check("hold_mulRes", regValMulRes, 64'hFFFFFFFE_00000001);
    end
    exHold = 1'b0;
    @(negedge clock);
    check("hold_release_idle", 64'(mulOK), 64'(UMEM_OK_READY));

    issue(JX2_UCMD_MULW3, 1'b0, 64'hAAAA8000, 64'h55558000, 0, 0, 64'h00000000_40000000, 1);
    issue(JX2_UCMD_MULW3, 1'b1, 64'h1234FFFF, 64'h4321FFFF, 0, 0, 64'h00000000_FFFE0001, 1);
    issue(JX2_UCMD_MULW3, 1'b0, 64'h0000FFFF, 64'h00000001, 0, 0, 64'hFFFFFFFF_FFFFFFFF, 1);
    @(negedge clock);
    check("mulw_no_fsm", 64'(mulOK), 64'(UMEM_OK_READY));
    check("mulw_keeps_mulRes", regValMulRes, 64'hFFFFFFFE_00000001);

    issue(JX2_UCMD_MUL3, 1'b0, 64'h80000000, 64'h7FFFFFFF, 0, 0, 64'hC0000000_80000000, 1);
    issue(JX2_UCMD_MULW3, 1'b0, 64'h00007FFF, 64'h0000FFFF, 0, 0, 64'hFFFFFFFF_FFFF8001, 1);
    waitFor(UMEM_OK_OK, 5, "m5_done");
    waitFor(UMEM_OK_READY, 3, "m5_idle");

    issue(JX2_UCMD_MUL3, 1'b1, 64'h11111111, 64'h22222222, 0, 0, 64'h0, 0);
    @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    check("midop_reset_mulOK", 64'(mulOK), 64'(UMEM_OK_READY));
    check("midop_reset_mulRes", regValMulRes, 64'h0);
    check("midop_reset_mulwRes", regValMulwRes, 64'h0);
    issue(JX2_UCMD_MUL3, 1'b1, 64'h00012345, 64'h00000010, 0, 0, 64'h00000000_00123450, 1);
    waitFor(UMEM_OK_OK, 5, "m6_done");
    waitFor(UMEM_OK_READY, 3, "m6_idle");

    issue(JX2_UCMD_MUL3, 1'b1, 64'h7, 64'h9, 1, 0, 64'h0, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("flush_no_capture", 64'(mulOK), 64'(UMEM_OK_READY));
    end
    issue(JX2_UCMD_MUL3, 1'b1, 64'h7, 64'h9, 0, 1, 64'h0, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("hold_no_capture", 64'(mulOK), 64'(UMEM_OK_READY));
    end
    check("nocap_mulRes", regValMulRes, 64'h00000000_00123450);

    issue(JX2_UCMD_MUL3, 1'b0, 64'hFFFFFFFE, 64'hFFFFFFFD, 0, 0, 64'h00000000_00000006, 1);
    waitFor(UMEM_OK_OK, 5, "b2b_first_done");
    issue(JX2_UCMD_MUL3, 1'b1, 64'h00010000, 64'h00010000, 0, 0, 64'h00000001_00000000, 1);
    waitFor(UMEM_OK_OK, 5, "b2b_second_done");
    waitFor(UMEM_OK_READY, 3, "b2b_idle");

    repeat (3) @(negedge clock);
    check("mul3_queue_drained", 64'(mulQ.size()), 64'h0);
    check("mulw_queue_drained", 64'(mulwQ.size()), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
